// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter feeding a registered 2:1 mux output stage.
// Latency: 1 cycle from an accepted input word to dataOut/validOut.
// Backpressure: readyOut low with validOut high freezes outputs, FSM and burst count; no grants are issued.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   dataIn0/validIn0      requester 0 word and valid; readyIn0 (comb.) = word taken this cycle
//   dataIn1/validIn1      requester 1 word and valid; readyIn1 (comb.) = word taken this cycle
//   dataOut/validOut      registered output word and its valid
//   srcOut                requester that produced dataOut (0 = in0, 1 = in1)
//   readyOut              consumer takes dataOut this cycle
module mux_rr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] dataIn0,
  input  logic              validIn0,
  output logic              readyIn0,
  input  logic [DATA_W-1:0] dataIn1,
  input  logic              validIn1,
  output logic              readyIn1,
  output logic [DATA_W-1:0] dataOut,
  output logic              validOut,
  output logic              srcOut,
  input  logic              readyOut
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  // Registered state
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_q;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q;
  logic                src_q;

  // Grant decision for the current cycle
  logic                ld;
  logic                gnt_vld;
  logic                gnt_sel;

  // Owner-relative views of the request lines, meaningful only in OWN0/OWN1
  logic                own_sel;
  logic                own_vld;
  logic                oth_vld;

  // The output register can take a new word when empty or being drained.
  // Only registered state and readyOut feed this, so validIn never reaches
  // validOut combinationally.
  assign ld = !valid_q | readyOut;

  assign own_sel = (state_q == OWN1);
  assign own_vld = own_sel ? validIn1 : validIn0;
  assign oth_vld = own_sel ? validIn0 : validIn1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_vld = 1'b0;
    gnt_sel = 1'b0;

    if (ld) begin
      unique case (state_q)
        IDLE: begin
          // A tie goes to whoever was not served last, so reset (last=1)
          // hands the first tie to requester 0.
          if (validIn0 && validIn1) begin
            gnt_vld = 1'b1;
            gnt_sel = ~last_q;
          end else if (validIn0) begin
            gnt_vld = 1'b1;
            gnt_sel = 1'b0;
          end else if (validIn1) begin
            gnt_vld = 1'b1;
            gnt_sel = 1'b1;
          end
          if (gnt_vld) begin
            state_d = gnt_sel ? OWN1 : OWN0;
            cnt_d   = CNT_ONE;
          end
        end

        OWN0, OWN1: begin
          // The owner keeps the grant until its burst is spent, but a sole
          // requester is never starved by its own burst limit.
          if (own_vld && ((cnt_q < CNT_MAX) || !oth_vld)) begin
            gnt_vld = 1'b1;
            gnt_sel = own_sel;
            if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else if (oth_vld) begin
            // Switch in the same cycle, with a fresh burst for the new owner.
            gnt_vld = 1'b1;
            gnt_sel = ~own_sel;
            state_d = own_sel ? OWN0 : OWN1;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A grant is only ever issued to a valid requester, so readyIn alone
  // marks the transfer; at most one of the two can be high.
  assign readyIn0 = gnt_vld & ~gnt_sel;
  assign readyIn1 = gnt_vld &  gnt_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
      src_q   <= 1'b0;
    end else if (ld) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= gnt_vld;
      if (gnt_vld) begin
        data_q <= gnt_sel ? dataIn1 : dataIn0;
        src_q  <= gnt_sel;
        last_q <= gnt_sel;
      end
    end
  end

  assign dataOut  = data_q;
  assign validOut = valid_q;
  assign srcOut   = src_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

  logic       clk;
  logic       reset;
  logic [7:0] dataIn0;
  logic       validIn0;
  logic       readyIn0;
  logic [7:0] dataIn1;
  logic       validIn1;
  logic       readyIn1;
  logic [7:0] dataOut;
  logic       validOut;
  logic       srcOut;
  logic       readyOut;

  int checks;
  int failures;

  mux_rr_arbiter #(
    .DATA_W   (8),
    .BURST_MAX(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .dataIn0  (dataIn0),
    .validIn0 (validIn0),
    .readyIn0 (readyIn0),
    .dataIn1  (dataIn1),
    .validIn1 (validIn1),
    .readyIn1 (readyIn1),
    .dataOut  (dataOut),
    .validOut (validOut),
    .srcOut   (srcOut),
    .readyOut (readyOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; readyOut = 1'b1;
    validIn0 = 1'b0; validIn1 = 1'b0; dataIn0 = 8'h00; dataIn1 = 8'h00;
    tick; tick;
    checks++; if (validOut !== 1'b0) begin failures++; $display("FAIL reset_validOut got=%0b exp=0", validOut); end
    checks++; if (dataOut !== 8'h00) begin failures++; $display("FAIL reset_dataOut got=%h exp=00", dataOut); end
    checks++; if (srcOut !== 1'b0) begin failures++; $display("FAIL reset_srcOut got=%0b exp=0", srcOut); end

    // Start a stream from in0 so last points at requester 0.
    reset = 1'b0;
    validIn0 = 1'b1; dataIn0 = 8'hA5;
    tick;
    checks++; if (validOut !== 1'b1 || dataOut !== 8'hA5) begin failures++; $display("FAIL reset_prestream got=%0b/%h exp=1/a5", validOut, dataOut); end

    // Asynchronous reset away from any clock edge.
    #3 reset = 1'b1;
    #1;
    checks++; if (validOut !== 1'b0) begin failures++; $display("FAIL reset_async_validOut got=%0b exp=0", validOut); end
    checks++; if (dataOut !== 8'h00) begin failures++; $display("FAIL reset_async_dataOut got=%h exp=00", dataOut); end
    checks++; if (srcOut !== 1'b0) begin failures++; $display("FAIL reset_async_srcOut got=%0b exp=0", srcOut); end

    validIn0 = 1'b1; dataIn0 = 8'h5A; validIn1 = 1'b1; dataIn1 = 8'hC3;
    tick;
    checks++; if (validOut !== 1'b0) begin failures++; $display("FAIL reset_held_validOut got=%0b exp=0", validOut); end
    reset = 1'b0;
    #1;
    checks++; if (readyIn0 !== 1'b1 || readyIn1 !== 1'b0) begin failures++; $display("FAIL reset_tie_ready got=%0b%0b exp=01", readyIn1, readyIn0); end
    tick;
    checks++; if (srcOut !== 1'b0 || dataOut !== 8'h5A || validOut !== 1'b1) begin failures++; $display("FAIL reset_tie_out got=%0b/%h/%0b exp=0/5a/1", srcOut, dataOut, validOut); end
    validIn0 = 1'b0; validIn1 = 1'b0;
    tick;
    checks++; if (validOut !== 1'b0) begin failures++; $display("FAIL reset_drain_validOut got=%0b exp=0", validOut); end
  endtask

  // in0 alone sends six words: exceeds the burst limit without losing the grant.
  task automatic test_single_lane;
    logic [7:0] w [0:5];
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44; w[4] = 8'h55; w[5] = 8'h66;
    readyOut = 1'b1; validIn1 = 1'b0; dataIn1 = 8'hEE;
    for (int i = 0; i < 6; i++) begin
      validIn0 = 1'b1; dataIn0 = w[i];
      #1;
      checks++; if (readyIn0 !== 1'b1 || readyIn1 !== 1'b0) begin failures++; $display("FAIL single_ready[%0d] got=%0b%0b exp=01", i, readyIn1, readyIn0); end
      tick;
      checks++; if (validOut !== 1'b1 || dataOut !== w[i] || srcOut !== 1'b0) begin failures++; $display("FAIL single_out[%0d] got=%0b/%h/%0b exp=1/%h/0", i, validOut, dataOut, srcOut, w[i]); end
    end
    validIn0 = 1'b0;
    tick;
    checks++; if (validOut !== 1'b0) begin failures++; $display("FAIL single_end_validOut got=%0b exp=0", validOut); end
  endtask

  task automatic test_contention;
    int exp_src [0:9];
    logic [7:0] exp_dat;
    exp_src[0] = 0; exp_src[1] = 0; exp_src[2] = 0; exp_src[3] = 0;
    exp_src[4] = 1; exp_src[5] = 1; exp_src[6] = 1; exp_src[7] = 1;
    exp_src[8] = 0; exp_src[9] = 0;
    readyOut = 1'b1;
    // One word from in1 so the next tie belongs to in0.
    validIn0 = 1'b0; validIn1 = 1'b1; dataIn1 = 8'h77;
    tick;
    checks++; if (srcOut !== 1'b1 || dataOut !== 8'h77) begin failures++; $display("FAIL cont_pre got=%0b/%h exp=1/77", srcOut, dataOut); end
    validIn1 = 1'b0;
    tick;
    validIn0 = 1'b1; dataIn0 = 8'hA0; validIn1 = 1'b1; dataIn1 = 8'hB1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if ((exp_src[i] == 1 && (readyIn1 !== 1'b1 || readyIn0 !== 1'b0)) ||
          (exp_src[i] == 0 && (readyIn0 !== 1'b1 || readyIn1 !== 1'b0))) begin
        failures++; $display("FAIL cont_ready[%0d] got=%0b%0b exp_src=%0d", i, readyIn1, readyIn0, exp_src[i]);
      end
      tick;
      exp_dat = (exp_src[i] == 1) ? 8'hB1 : 8'hA0;
      checks++; if (srcOut !== exp_src[i][0] || dataOut !== exp_dat) begin failures++; $display("FAIL cont_out[%0d] got=%0b/%h exp=%0d/%h", i, srcOut, dataOut, exp_src[i], exp_dat); end
    end
    validIn0 = 1'b0; validIn1 = 1'b0;
    tick;
  endtask

  // Both requesters stream 8 words each; consumer stalls 3 cycles mid-burst.
  task automatic test_backpressure;
    logic [7:0] exp_q [0:15];
    logic [7:0] rec_d [0:15];
    logic       rec_s [0:15];
    logic [7:0] prev;
    logic       acc0, acc1, take, stall;
    int i0, i1, nrec, cyc;
    for (int i = 0; i < 4; i++) begin
      exp_q[i]      = 8'h81 + 8'(i);
      exp_q[i + 4]  = 8'h01 + 8'(i);
      exp_q[i + 8]  = 8'h85 + 8'(i);
      exp_q[i + 12] = 8'h05 + 8'(i);
    end
    i0 = 0; i1 = 0; nrec = 0; cyc = 0;
    while (nrec < 16 && cyc < 60) begin
      validIn0 = (i0 < 8); dataIn0 = 8'h01 + 8'(i0);
      validIn1 = (i1 < 8); dataIn1 = 8'h81 + 8'(i1);
      readyOut = !(cyc >= 2 && cyc <= 4);
      #1;
      acc0  = validIn0 & readyIn0;
      acc1  = validIn1 & readyIn1;
      take  = validOut & readyOut;
      stall = validOut & !readyOut;
      if (stall) begin
        checks++; if (readyIn0 !== 1'b0 || readyIn1 !== 1'b0) begin failures++; $display("FAIL bp_stall_ready[%0d] got=%0b%0b exp=00", cyc, readyIn1, readyIn0); end
      end
      if (take && nrec < 16) begin
        rec_d[nrec] = dataOut; rec_s[nrec] = srcOut; nrec++;
      end
      prev = dataOut;
      tick;
      if (acc0) i0++;
      if (acc1) i1++;
      if (stall) begin
        checks++; if (validOut !== 1'b1 || dataOut !== prev) begin failures++; $display("FAIL bp_hold[%0d] got=%0b/%h exp=1/%h", cyc, validOut, dataOut, prev); end
      end
      cyc++;
    end
    validIn0 = 1'b0; validIn1 = 1'b0; readyOut = 1'b1;
    tick;
    checks++; if (nrec != 16) begin failures++; $display("FAIL bp_count got=%0d exp=16", nrec); end
    for (int i = 0; i < nrec; i++) begin
      checks++; if (rec_d[i] !== exp_q[i] || rec_s[i] !== exp_q[i][7]) begin failures++; $display("FAIL bp_seq[%0d] got=%h/%0b exp=%h/%0b", i, rec_d[i], rec_s[i], exp_q[i], exp_q[i][7]); end
    end
  endtask

  task automatic test_early_yield;
    logic v0s [0:6];
    logic v1s [0:6];
    logic exps [0:6];
    logic [7:0] exp_dat;
    v0s[0]=1; v0s[1]=1; v0s[2]=0; v0s[3]=1; v0s[4]=1; v0s[5]=1; v0s[6]=1;
    v1s[0]=0; v1s[1]=1; v1s[2]=1; v1s[3]=1; v1s[4]=1; v1s[5]=1; v1s[6]=1;
    exps[0]=0; exps[1]=0; exps[2]=1; exps[3]=1; exps[4]=1; exps[5]=1; exps[6]=0;
    readyOut = 1'b1; dataIn0 = 8'h0A; dataIn1 = 8'h1B;
    for (int i = 0; i < 7; i++) begin
      validIn0 = v0s[i]; validIn1 = v1s[i];
      #1;
      checks++; if (readyIn1 !== exps[i] || readyIn0 !== ~exps[i]) begin failures++; $display("FAIL yield_ready[%0d] got=%0b%0b exp_src=%0b", i, readyIn1, readyIn0, exps[i]); end
      tick;
      exp_dat = exps[i] ? 8'h1B : 8'h0A;
      checks++; if (validOut !== 1'b1 || srcOut !== exps[i] || dataOut !== exp_dat) begin failures++; $display("FAIL yield_out[%0d] got=%0b/%0b/%h exp=1/%0b/%h", i, validOut, srcOut, dataOut, exps[i], exp_dat); end
    end
    validIn0 = 1'b0; validIn1 = 1'b0;
    tick;
  endtask

  task automatic test_idle_gap;
    readyOut = 1'b1;
    validIn0 = 1'b1; dataIn0 = 8'h3C; validIn1 = 1'b0; dataIn1 = 8'h4D;
    tick;
    checks++; if (srcOut !== 1'b0 || dataOut !== 8'h3C) begin failures++; $display("FAIL idle_pre got=%0b/%h exp=0/3c", srcOut, dataOut); end
    validIn0 = 1'b0;
    tick;
    checks++; if (validOut !== 1'b0) begin failures++; $display("FAIL idle_gap1 got=%0b exp=0", validOut); end
    tick;
    checks++; if (validOut !== 1'b0) begin failures++; $display("FAIL idle_gap2 got=%0b exp=0", validOut); end
    validIn0 = 1'b1; validIn1 = 1'b1;
    #1;
    checks++; if (readyIn1 !== 1'b1 || readyIn0 !== 1'b0) begin failures++; $display("FAIL idle_tie_ready got=%0b%0b exp=10", readyIn1, readyIn0); end
    tick;
    checks++; if (validOut !== 1'b1 || srcOut !== 1'b1 || dataOut !== 8'h4D) begin failures++; $display("FAIL idle_tie_out got=%0b/%0b/%h exp=1/1/4d", validOut, srcOut, dataOut); end
    tick;
    checks++; if (srcOut !== 1'b1) begin failures++; $display("FAIL idle_burst got=%0b exp=1", srcOut); end
    validIn0 = 1'b0; validIn1 = 1'b0;
    tick;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset;
    test_single_lane;
    test_contention;
    test_backpressure;
    test_early_yield;
    test_idle_gap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
